mux_sel_arb4: RTL
=================

MUX_SEL_ARB4 -- requirements
Module: mux_sel_arb4

Interface
REQ-001 SHALL have parameter MaxBurst, default 4: maximum consecutive cycles one requester holds the grant; legal range 1..15.
REQ-002 SHALL have port clk_i, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_i, input, 4: request per channel (bit n = channel n, same index order as the downstream 4:1 select a/b/c/d = 0/1/2/3).
REQ-005 SHALL have port hold_i, input, 1: freezes all arbiter state and outputs while high.
REQ-006 SHALL have port sel_o, output, 2: channel index to drive the downstream mux select.
REQ-007 SHALL have port gnt_o, output, 4: one-hot grant, all zero when no owner.
REQ-008 SHALL have port valid_o, output, 1: high when gnt_o is non-zero and sel_o names a live owner.
REQ-009 SHALL have port burst_cnt_o, output, 4: number of cycles the current owner has held the grant, 0 when idle.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL register all outputs; grant appears 1 cycle after the request is sampled.
REQ-012 SHALL keep a last-winner pointer; arbitration scans from (last+1) mod 4 upward with wrap-around, and the first asserted req_i bit wins.
REQ-013 IDLE -> GRANT when any req_i bit is 1: owner = winner, gnt_o = one-hot(owner), sel_o = owner, valid_o = 1, burst_cnt_o = 1, last = owner.
REQ-014 IDLE with req_i = 0: stay IDLE, gnt_o = 0, valid_o = 0, burst_cnt_o = 0, sel_o holds its previous value.
REQ-015 GRANT, req_i[owner] = 1 and burst_cnt_o < MaxBurst: keep owner, burst_cnt_o increments by 1.
REQ-016 GRANT, req_i[owner] = 0 or burst_cnt_o = MaxBurst: re-arbitrate in the same cycle from (owner+1) mod 4, treating the owner's bit as an ordinary request (lowest priority). The new grant takes effect next cycle with no idle bubble, and burst_cnt_o = 1.
REQ-017 In REQ-016, if only the owner still requests, the owner SHALL be re-granted with burst_cnt_o = 1.
REQ-018 In REQ-016, if no bit of req_i is set: go IDLE next cycle, gnt_o = 0, valid_o = 0, burst_cnt_o = 0.
REQ-019 hold_i = 1 SHALL freeze FSM state, pointer, counter and all outputs regardless of req_i; on release, evaluation resumes with the frozen counter value.
REQ-020 burst_cnt_o SHALL never exceed MaxBurst and SHALL never wrap.
REQ-021 gnt_o SHALL always be zero or one-hot, and SHALL equal one-hot(sel_o) whenever valid_o = 1.
REQ-022 A request may be dropped at any cycle; the grant may persist 1 cycle after the drop because outputs are registered.

Reset
REQ-023 While rst_i is high, regardless of clock: state = IDLE, sel_o = 0, gnt_o = 0, valid_o = 0, burst_cnt_o = 0, last pointer = 3 (channel 0 has first priority).
REQ-024 Reset asserted mid-GRANT SHALL clear outputs immediately (asynchronous); the first grant after deassertion follows REQ-013 from pointer = 3.
REQ-025 Reset takes precedence over hold_i.

Verification
REQ-026 Reset, then req_i = 4'b1111 held, MaxBurst = 4: owner 0 for 4 cycles (burst_cnt_o 1, 2, 3, 4), then 1, 2, 3, 0, each for 4 cycles, with no valid_o gap.
REQ-027 Single requester: req_i = 4'b0100 held for 10 cycles: sel_o = 2 and valid_o = 1 throughout; burst_cnt_o sequence 1, 2, 3, 4, 1, 2, 3, 4, 1, 2.
REQ-028 Early release: owner 1 granted, drop req_i[1] at burst_cnt_o = 2 while req_i[3] = 1: next cycle sel_o = 3, gnt_o = 4'b1000, burst_cnt_o = 1.
REQ-029 Wrap-around: last = 3, req_i = 4'b1001: channel 0 wins; next arbitration with both still requesting gives channel 3.
REQ-030 hold_i = 1 for 5 cycles at burst_cnt_o = 2 with req_i changing: all outputs constant; after release, burst_cnt_o continues 3, 4.
REQ-031 Async reset pulsed mid-burst between clock edges: outputs zero before the next edge; after release with req_i = 4'b0010, sel_o = 1 one cycle later.

Source files
------------

// File: rtl/mux_sel_arb4.sv
// Round-robin 4-channel arbiter with burst limit, driving a downstream 4:1 mux select.
// All outputs are registered; hold_i freezes every flop.
module mux_sel_arb4 #(
  parameter int unsigned MaxBurst = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       hold_i,
  output logic [1:0] sel_o,
  output logic [3:0] gnt_o,
  output logic       valid_o,
  output logic [3:0] burst_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [3:0] cnt_q, cnt_d;

  // Scan from last+1 upward; offset 4 wraps back to last itself, so it has lowest priority.
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  logic [1:0] winner;
  logic       keep_owner;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    winner     = pick_winner(req_i, last_q);
    keep_owner = (state_q == GRANT) && req_i[sel_q] && (cnt_q < 4'(MaxBurst));

    if (!hold_i) begin
      if (keep_owner) begin
        cnt_d = cnt_q + 4'd1;
      end else if (req_i != 4'b0000) begin
        // In GRANT, last_q equals the owner, so the same scan serves both states.
        state_d = GRANT;
        last_d  = winner;
        sel_d   = winner;
        gnt_d   = 4'b0001 << winner;
        valid_d = 1'b1;
        cnt_d   = 4'd1;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign valid_o     = valid_q;
  assign burst_cnt_o = cnt_q;

endmodule
